// File: rtl/bcd_ctrl_pkg.sv
// Shared opcodes, FSM encoding and BCD helpers for the BCD counter controller.
package bcd_ctrl_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_COUNT = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Out-of-range load digits saturate to 9.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0-9) of the cascaded counter chain; load takes priority over step.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       step,
  input  logic       dir,
  output logic [3:0] q,
  output logic       term
);

  logic [3:0] q_q, q_d;

  // Next digit value: load, or step up/down with 9<->0 rollover.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      if (dir) begin
        q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end else begin
        q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  // Terminal value: the next digit up the chain steps when this one rolls over.
  assign term = dir ? (q_q == BCD_MAX) : (q_q == 4'd0);

endmodule

// File: rtl/bcd_count_ctrl.sv
// Command sequencer for a cascaded BCD up/down counter: CLEAR/LOAD/COUNT over valid/ready.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned STEP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic                  cmd_dir,
  input  logic [STEP_W-1:0]     cmd_steps,
  input  logic [4*DIGITS-1:0]   cmd_data,
  input  logic                  hold,
  output logic [4*DIGITS-1:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap,
  output logic                  load_err
);

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                dir_q, dir_d;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;

  logic                accept;
  logic                step_en;
  logic                dig_load;
  logic [DIGITS-1:0]   term;
  logic [DIGITS-1:0]   bad_digit;
  logic [DIGITS:0]     carry;
  logic [3:0]          load_val [DIGITS];
  logic [3:0]          digit_q  [DIGITS];

  assign accept   = cmd_valid && cmd_ready;
  assign step_en  = (state_q == ST_RUN) && !hold;
  assign dig_load = accept && ((cmd_op == OP_CLEAR) || (cmd_op == OP_LOAD));
  assign carry[0] = step_en;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign bad_digit[k] = cmd_data[4*k +: 4] > BCD_MAX;
    assign load_val[k]  = (cmd_op == OP_LOAD) ? bcd_clamp(cmd_data[4*k +: 4]) : 4'd0;
    // Digit k steps only when every lower digit sits at its terminal value.
    assign carry[k+1]   = carry[k] && term[k];
    assign count[4*k +: 4] = digit_q[k];

    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (dig_load),
      .load_val (load_val[k]),
      .step     (carry[k]),
      .dir      (dir_q),
      .q        (digit_q[k]),
      .term     (term[k])
    );
  end

  // Next-state: command decode, step countdown and sticky flag updates.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    wrap_d     = wrap_q;
    load_err_d = load_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wrap_d     = 1'b0;
          load_err_d = 1'b0;
          state_d    = ST_DONE;
          case (cmd_op)
            OP_LOAD:  load_err_d = |bad_digit;
            OP_COUNT: begin
              if (cmd_steps != '0) begin
                rem_d   = cmd_steps;
                dir_d   = cmd_dir;
                state_d = ST_RUN;
              end
            end
            default:  ;
          endcase
        end
      end
      ST_RUN: begin
        if (!hold) begin
          rem_d = rem_q - 1'b1;
          // Carry out of the top digit means the whole chain rolled over.
          if (carry[DIGITS]) begin
            wrap_d = 1'b1;
          end
          if (rem_q == STEP_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = !cmd_ready;
  assign done      = (state_q == ST_DONE);
  assign wrap      = wrap_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Directed bench for bcd_count_ctrl (DIGITS=2, STEP_W=8).
module tb_bcd_count_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [7:0] cmd_steps;
  logic [7:0] cmd_data;
  logic       hold;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       wrap;
  logic       load_err;

  int checks = 0;
  int errors = 0;

  bcd_count_ctrl #(
    .DIGITS (2),
    .STEP_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_data  (cmd_data),
    .hold      (hold),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic       dir;
    logic [7:0] steps;
    logic [7:0] data;
    logic [7:0] exp_count;
    logic       exp_le;
    logic       exp_wrap;
    int         exp_lat;
  } vec_t;

  vec_t vec [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command and wait (bounded) for done; lat = cycles after the accept edge.
  task automatic run_cmd(input logic [1:0] op, input logic dir, input logic [7:0] steps,
                         input logic [7:0] data, output int lat);
    int w;
    w = 0;
    while (!cmd_ready && w < 400) begin
      tick();
      w++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dir   = dir;
    cmd_steps = steps;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      tick();
      lat++;
    end
    check("done_seen", int'(done), 1);
  endtask

  function automatic vec_t mk(logic [1:0] op, logic dir, logic [7:0] steps, logic [7:0] data,
                              logic [7:0] ec, logic le, logic w, int lat);
    vec_t v;
    v.op = op; v.dir = dir; v.steps = steps; v.data = data;
    v.exp_count = ec; v.exp_le = le; v.exp_wrap = w; v.exp_lat = lat;
    return v;
  endfunction

  initial begin
    int lat;
    int dones;
    int accepts;
    logic [7:0] up_seq [7];

    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_dir = 1'b0;
    cmd_steps = 8'd0; cmd_data = 8'd0; hold = 1'b0;

    vec[0]  = mk(2'b01, 1'b0, 8'd0,   8'h47, 8'h47, 1'b0, 1'b0, 0);
    vec[1]  = mk(2'b01, 1'b0, 8'd0,   8'h4C, 8'h49, 1'b1, 1'b0, 0);
    vec[2]  = mk(2'b01, 1'b0, 8'd0,   8'h95, 8'h95, 1'b0, 1'b0, 0);
    vec[3]  = mk(2'b10, 1'b1, 8'd7,   8'h00, 8'h02, 1'b0, 1'b1, 7);
    vec[4]  = mk(2'b01, 1'b0, 8'd0,   8'h03, 8'h03, 1'b0, 1'b0, 0);
    vec[5]  = mk(2'b10, 1'b0, 8'd5,   8'h00, 8'h98, 1'b0, 1'b1, 5);
    vec[6]  = mk(2'b00, 1'b0, 8'd0,   8'h77, 8'h00, 1'b0, 1'b0, 0);
    vec[7]  = mk(2'b10, 1'b1, 8'd0,   8'h00, 8'h00, 1'b0, 1'b0, 0);
    vec[8]  = mk(2'b11, 1'b1, 8'd9,   8'h55, 8'h00, 1'b0, 1'b0, 0);
    vec[9]  = mk(2'b01, 1'b0, 8'd0,   8'hF9, 8'h99, 1'b1, 1'b0, 0);
    vec[10] = mk(2'b10, 1'b1, 8'd1,   8'h00, 8'h00, 1'b0, 1'b1, 1);
    vec[11] = mk(2'b10, 1'b0, 8'd12,  8'h00, 8'h88, 1'b0, 1'b1, 12);
    vec[12] = mk(2'b01, 1'b0, 8'd0,   8'h5A, 8'h59, 1'b1, 1'b0, 0);
    vec[13] = mk(2'b10, 1'b1, 8'd250, 8'h00, 8'h09, 1'b0, 1'b1, 250);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_load_err", int'(load_err), 0);
    rst = 1'b1;
    tick();

    // Table-driven commands
    for (int i = 0; i < 14; i++) begin
      run_cmd(vec[i].op, vec[i].dir, vec[i].steps, vec[i].data, lat);
      check($sformatf("v%0d_count", i), int'(count), int'(vec[i].exp_count));
      check($sformatf("v%0d_load_err", i), int'(load_err), int'(vec[i].exp_le));
      check($sformatf("v%0d_wrap", i), int'(wrap), int'(vec[i].exp_wrap));
      check($sformatf("v%0d_latency", i), lat, vec[i].exp_lat);
      check($sformatf("v%0d_busy_in_done", i), int'(busy), 1);
      tick();
      check($sformatf("v%0d_done_pulse", i), int'(done), 0);
      check($sformatf("v%0d_ready_after", i), int'(cmd_ready), 1);
    end

    // Edge-by-edge up count through 99 -> 00
    up_seq = '{8'h96, 8'h97, 8'h98, 8'h99, 8'h00, 8'h01, 8'h02};
    run_cmd(2'b01, 1'b0, 8'd0, 8'h95, lat);
    tick();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dir = 1'b1; cmd_steps = 8'd7;
    tick();
    cmd_valid = 1'b0;
    check("seq_hold_at_accept", int'(count), 8'h95);
    dones = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("seq_up_%0d", i), int'(count), int'(up_seq[i]));
      dones += int'(done);
    end
    tick();
    dones += int'(done);
    check("seq_up_done_once", dones, 1);
    check("seq_up_wrap", int'(wrap), 1);

    // Hold freezes stepping for 3 cycles after the 2nd step
    run_cmd(2'b00, 1'b0, 8'd0, 8'h00, lat);
    tick();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dir = 1'b1; cmd_steps = 8'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("hold_pre", int'(count), 8'h02);
    hold = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      dones += int'(done);
    end
    check("hold_frozen", int'(count), 8'h02);
    check("hold_no_done", dones, 0);
    hold = 1'b0;
    tick();
    check("hold_resume", int'(count), 8'h03);
    check("hold_not_done_yet", int'(done), 0);
    tick();
    check("hold_final", int'(count), 8'h04);
    check("hold_done_delayed", int'(done), 1);
    tick();

    // Reset mid-RUN abandons the command
    run_cmd(2'b01, 1'b0, 8'd0, 8'h95, lat);
    tick();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dir = 1'b1; cmd_steps = 8'd10;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    check("mid_count", int'(count), 8'h01);
    check("mid_wrap", int'(wrap), 1);
    #1 rst = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_ready", int'(cmd_ready), 1);
    check("arst_wrap", int'(wrap), 0);
    check("arst_done", int'(done), 0);
    tick();
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      dones += int'(done);
    end
    check("arst_no_done", dones, 0);
    check("arst_count_stays", int'(count), 0);

    // cmd_valid held high: one accept per idle period
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_dir = 1'b1; cmd_steps = 8'd3;
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid && cmd_ready) accepts++;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("held_accepts", accepts, 2);
    check("held_count", int'(count), 8'h06);
    check("held_ready", int'(cmd_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
